// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler_if
//  Description : Control/lamp bundle for the intersection phase scheduler.
//                master : request/enable source, lamp consumer
//                slave  : the scheduler itself
//  Signals     : en        advance enable (0 freezes the scheduler)
//                side_req  side-road vehicle sensor
//                ped_req   pedestrian push-button
//                main_lt   main-road lamps {R,Y,G}
//                side_lt   side-road lamps {R,Y,G}
//                ped_walk  walk lamp
//                ped_ack   one-cycle pulse on entry to the walk phase
//                phase     current state code (debug)
//  Revision    : 1.0  initial release
// ============================================================================
interface traffic_phase_scheduler_if;
    logic       en;
    logic       side_req;
    logic       ped_req;
    logic [2:0] main_lt;
    logic [2:0] side_lt;
    logic       ped_walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output en, side_req, ped_req,
        input  main_lt, side_lt, ped_walk, ped_ack, phase
    );

    modport slave (
        input  en, side_req, ped_req,
        output main_lt, side_lt, ped_walk, ped_ack, phase
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler
//  Description : Phase scheduler for a two-road intersection with a
//                pedestrian crossing. Main road rests in green; side-road and
//                pedestrian requests are latched and, when both are pending,
//                served round-robin. Every service returns through main green.
//  Ports       : clk    clock, rising edge
//                res_n  synchronous reset, active HIGH (name shared with the
//                       sibling traffic blocks)
//                bus    traffic_phase_scheduler_if.slave (enable, requests,
//                       lamp one-hots, walk lamp, walk ack, phase code)
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int CNT_W     = 5,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int PED_T     = 6
) (
    input  wire logic                clk,
    input  wire logic                res_n,
    traffic_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        ALLRED1  = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4,
        ALLRED2  = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    // Counter value on the last enabled cycle of each timed phase.
    localparam logic [CNT_W-1:0] c_GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_PED_LAST  = CNT_W'(PED_T - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             last_srv_q, last_srv_d;   // 0 = side served last, 1 = ped

    logic             enter_side;
    logic             enter_ped;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GRN: begin
                if (bus.en && (cnt_q >= c_GMIN_LAST) && (side_pend_q || ped_pend_q))
                    state_d = MAIN_YEL;
            end
            MAIN_YEL: begin
                if (bus.en && (cnt_q == c_YEL_LAST))
                    state_d = ALLRED1;
            end
            ALLRED1: begin
                if (bus.en && (cnt_q == c_AR_LAST)) begin
                    if (side_pend_q && ped_pend_q)
                        state_d = last_srv_q ? SIDE_GRN : PED_WALK;
                    else if (side_pend_q)
                        state_d = SIDE_GRN;
                    else if (ped_pend_q)
                        state_d = PED_WALK;
                    else
                        // Nothing left to serve: clear back to main.
                        state_d = ALLRED2;
                end
            end
            SIDE_GRN: begin
                // Gap-out looks at the live sensor, not the latched flag,
                // since the flag is held clear for the whole side green.
                if (bus.en && (cnt_q >= c_GMIN_LAST) &&
                    (!bus.side_req || (cnt_q == c_GMAX_LAST)))
                    state_d = SIDE_YEL;
            end
            SIDE_YEL: begin
                if (bus.en && (cnt_q == c_YEL_LAST))
                    state_d = ALLRED2;
            end
            PED_WALK: begin
                if (bus.en && (cnt_q == c_PED_LAST))
                    state_d = ALLRED2;
            end
            ALLRED2: begin
                if (bus.en && (cnt_q == c_AR_LAST))
                    state_d = MAIN_GRN;
            end
            // Illegal code recovers regardless of enable.
            default: state_d = MAIN_GRN;
        endcase
    end

    assign enter_side = (state_d == SIDE_GRN) && (state_q != SIDE_GRN);
    assign enter_ped  = (state_d == PED_WALK) && (state_q != PED_WALK);

    // ------------------------------------------------------------------------
    // Counter, pending flags and round-robin pointer
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        side_pend_d = side_pend_q;
        ped_pend_d  = ped_pend_q;
        last_srv_d  = last_srv_q;

        if (state_d != state_q)
            cnt_d = '0;
        else if (bus.en && (cnt_q != c_CNT_MAX))
            cnt_d = cnt_q + 1'b1;

        if (bus.en) begin
            // Clear on entry takes priority over a coincident set.
            if (enter_side)
                side_pend_d = 1'b0;
            else if (bus.side_req && (state_q != SIDE_GRN))
                side_pend_d = 1'b1;

            if (enter_ped)
                ped_pend_d = 1'b0;
            else if (bus.ped_req && (state_q != PED_WALK))
                ped_pend_d = 1'b1;
        end

        if (enter_side)
            last_srv_d = 1'b0;
        else if (enter_ped)
            last_srv_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res_n) begin
            state_q     <= MAIN_GRN;
            cnt_q       <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            last_srv_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            last_srv_q  <= last_srv_d;
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    assign bus.main_lt  = (state_q == MAIN_GRN) ? 3'b001 :
                          (state_q == MAIN_YEL) ? 3'b010 : 3'b100;
    assign bus.side_lt  = (state_q == SIDE_GRN) ? 3'b001 :
                          (state_q == SIDE_YEL) ? 3'b010 : 3'b100;
    assign bus.ped_walk = (state_q == PED_WALK);
    // The counter only reads zero on the first walk cycle (and stays there
    // while disabled), which gives the single-cycle acknowledge.
    assign bus.ped_ack  = (state_q == PED_WALK) && (cnt_q == '0);
    assign bus.phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_scheduler
//  Description : Self-checking bench for traffic_phase_scheduler. A
//                dwell-time reference model tracks the phase, the number of
//                enabled cycles spent in it, the latched requests and the
//                round-robin turn; a run-length table covers the basic
//                side-road cycle and hand sequences cover the corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int PED_T     = 6;

    logic clk = 1'b0;
    logic res_n;
    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .CNT_W    (5),
        .GREEN_MIN(GREEN_MIN),
        .GREEN_MAX(GREEN_MAX),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .PED_T    (PED_T)
    ) dut (
        .clk  (clk),
        .res_n(res_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase number, enabled cycles already spent in it,
    // latched requests, and who was served last (1 = pedestrian).
    int m_phase = 0;
    int m_el    = 0;
    bit m_side  = 1'b0;
    bit m_ped   = 1'b0;
    bit m_last  = 1'b1;

    function automatic logic [2:0] lamp_main(input int p);
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] lamp_side(input int p);
        return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit sr, input bit pr);
        int run;
        int nxt;
        if (rst) begin
            m_phase = 0; m_el = 0; m_side = 1'b0; m_ped = 1'b0; m_last = 1'b1;
            return;
        end
        if (!en) return;
        run = m_el + 1;               // enabled cycles in this phase, including this one
        nxt = m_phase;
        case (m_phase)
            0: if (run >= GREEN_MIN && (m_side || m_ped)) nxt = 1;
            1: if (run == YELLOW_T) nxt = 2;
            2: if (run == ALLRED_T) begin
                   if (m_side && m_ped) nxt = m_last ? 3 : 6;
                   else if (m_side)     nxt = 3;
                   else if (m_ped)      nxt = 6;
                   else                 nxt = 5;
               end
            3: if (run >= GREEN_MIN && (!sr || run == GREEN_MAX)) nxt = 4;
            4: if (run == YELLOW_T) nxt = 5;
            5: if (run == ALLRED_T) nxt = 0;
            6: if (run == PED_T) nxt = 5;
            default: nxt = 0;
        endcase
        m_side = (nxt == 3 && m_phase != 3) ? 1'b0 : (m_side | (sr && m_phase != 3));
        m_ped  = (nxt == 6 && m_phase != 6) ? 1'b0 : (m_ped  | (pr && m_phase != 6));
        if (nxt == 3 && m_phase != 3) m_last = 1'b0;
        if (nxt == 6 && m_phase != 6) m_last = 1'b1;
        m_el    = (nxt != m_phase) ? 0 : run;
        m_phase = nxt;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic tick(input bit rst, input bit en, input bit sr, input bit pr);
        res_n        = rst;
        bus.en       = en;
        bus.side_req = sr;
        bus.ped_req  = pr;
        @(posedge clk);
        model_step(rst, en, sr, pr);
        #1;
        check("model_phase",    32'(bus.phase),    32'(m_phase[2:0]));
        check("model_main_lt",  32'(bus.main_lt),  32'(lamp_main(m_phase)));
        check("model_side_lt",  32'(bus.side_lt),  32'(lamp_side(m_phase)));
        check("model_ped_walk", 32'(bus.ped_walk), 32'(m_phase == 6));
        check("model_ped_ack",  32'(bus.ped_ack),  32'(m_phase == 6 && m_el == 0));
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        bit         sr;
        bit         pr;
        int         reps;
        logic [2:0] phase;
        logic [2:0] main_lt;
        logic [2:0] side_lt;
    } vec_t;

    function automatic vec_t v(input bit rst, input bit en, input bit sr, input bit pr,
                               input int reps, input logic [2:0] ph,
                               input logic [2:0] mn, input logic [2:0] sd);
        vec_t r;
        r.rst = rst; r.en = en; r.sr = sr; r.pr = pr;
        r.reps = reps; r.phase = ph; r.main_lt = mn; r.side_lt = sd;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_side;
        int t_ped;
        int acks;
        int walks;
        int y;
        int bad;

        res_n = 1'b1; bus.en = 1'b0; bus.side_req = 1'b0; bus.ped_req = 1'b0;

        // Side-road cycle after a single-cycle request (gap-out).
        tbl.push_back(v(1, 1, 0, 0, 1, 3'd0, 3'b001, 3'b100));
        tbl.push_back(v(0, 1, 1, 0, 1, 3'd0, 3'b001, 3'b100));
        tbl.push_back(v(0, 1, 0, 0, 6, 3'd0, 3'b001, 3'b100));
        tbl.push_back(v(0, 1, 0, 0, 3, 3'd1, 3'b010, 3'b100));
        tbl.push_back(v(0, 1, 0, 0, 1, 3'd2, 3'b100, 3'b100));
        tbl.push_back(v(0, 1, 0, 0, 8, 3'd3, 3'b100, 3'b001));
        tbl.push_back(v(0, 1, 0, 0, 3, 3'd4, 3'b100, 3'b010));
        tbl.push_back(v(0, 1, 0, 0, 1, 3'd5, 3'b100, 3'b100));
        tbl.push_back(v(0, 1, 0, 0, 5, 3'd0, 3'b001, 3'b100));

        // ---- Idle: reset then 40 cycles with no requests ----
        tick(1, 1, 0, 0);
        check("reset_phase",   32'(bus.phase),   32'd0);
        check("reset_main_lt", 32'(bus.main_lt), 32'b001);
        check("reset_side_lt", 32'(bus.side_lt), 32'b100);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 0, 0);
            if (bus.phase != 3'd0 || bus.main_lt != 3'b001 || bus.side_lt != 3'b100) bad++;
        end
        check("idle_rest_main_green", 32'(bad), 32'd0);

        // ---- Table: basic side service ----
        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                tick(tbl[k].rst, tbl[k].en, tbl[k].sr, tbl[k].pr);
                check("tbl_phase",   32'(bus.phase),   32'(tbl[k].phase));
                check("tbl_main_lt", 32'(bus.main_lt), 32'(tbl[k].main_lt));
                check("tbl_side_lt", 32'(bus.side_lt), 32'(tbl[k].side_lt));
            end
        end

        // ---- Max-out with side_req held ----
        tick(1, 1, 0, 0);
        for (int i = 0; i < 50 && bus.phase != 3'd3; i++) tick(0, 1, 1, 0);
        check("maxout_reach_side", 32'(bus.phase), 32'd3);
        n = 0;
        for (int i = 0; i < 60 && bus.phase == 3'd3; i++) begin n++; tick(0, 1, 1, 0); end
        check("maxout_side_green_len", 32'(n), 32'(GREEN_MAX));
        for (int i = 0; i < 20 && bus.phase != 3'd0; i++) tick(0, 1, 1, 0);
        check("maxout_back_to_main", 32'(bus.phase), 32'd0);
        n = 0;
        for (int i = 0; i < 60 && bus.phase == 3'd0; i++) begin n++; tick(0, 1, 1, 0); end
        check("maxout_main_green_len", 32'(n), 32'(GREEN_MIN));
        for (int i = 0; i < 20 && bus.phase != 3'd3; i++) tick(0, 1, 1, 0);
        check("maxout_side_again", 32'(bus.phase), 32'd3);

        // ---- Simultaneous side + ped after reset: side first, then ped ----
        tick(1, 1, 0, 0);
        tick(0, 1, 1, 1);
        t_side = -1; t_ped = -1; acks = 0; walks = 0;
        for (int i = 0; i < 80; i++) begin
            tick(0, 1, 0, 0);
            if (bus.phase == 3'd3 && t_side < 0) t_side = i;
            if (bus.phase == 3'd6 && t_ped < 0)  t_ped = i;
            if (bus.ped_ack)  acks++;
            if (bus.ped_walk) walks++;
        end
        check("rr_side_served",  32'(t_side >= 0), 32'd1);
        check("rr_side_first",   32'(t_side >= 0 && t_ped > t_side), 32'd1);
        check("rr_ped_ack_once", 32'(acks),  32'd1);
        check("rr_walk_len",     32'(walks), 32'(PED_T));
        check("rr_final_main",   32'(bus.phase), 32'd0);

        // ---- Enable freeze in main yellow ----
        tick(1, 1, 0, 0);
        tick(0, 1, 1, 0);
        for (int i = 0; i < 20 && bus.phase != 3'd1; i++) tick(0, 1, 0, 0);
        check("freeze_reach_yellow", 32'(bus.phase), 32'd1);
        y = 1;
        tick(0, 1, 0, 0);
        if (bus.phase == 3'd1) y++;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, 1);
            check("freeze_phase",   32'(bus.phase),   32'd1);
            check("freeze_main_lt", 32'(bus.main_lt), 32'b010);
        end
        for (int i = 0; i < 10 && bus.phase == 3'd1; i++) begin
            tick(0, 1, 0, 0);
            if (bus.phase == 3'd1) y++;
        end
        check("freeze_yellow_enabled_len", 32'(y), 32'(YELLOW_T));
        check("freeze_after_yellow", 32'(bus.phase), 32'd2);

        // ---- Reset during side green drops pending ped ----
        tick(1, 1, 0, 0);
        tick(0, 1, 1, 1);
        for (int i = 0; i < 30 && bus.phase != 3'd3; i++) tick(0, 1, 1, 0);
        check("midrst_reach_side", 32'(bus.phase), 32'd3);
        tick(0, 1, 1, 0);
        tick(1, 1, 0, 0);
        check("midrst_phase",   32'(bus.phase),   32'd0);
        check("midrst_main_lt", 32'(bus.main_lt), 32'b001);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick(0, 1, 0, 0);
            if (bus.phase != 3'd0 || bus.ped_walk) bad++;
        end
        check("midrst_ped_dropped", 32'(bad), 32'd0);

        // ---- Randomized run against the model ----
        tick(1, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
